seq_divider: RTL and testbench

Multi-cycle restoring divider for the ALU datapath: takes a 32-bit dividend and divisor, produces one quotient bit per clock, and presents the packed 64-bit result on `DivAns`. It feeds the Hi/Lo result register directly upstream: `DivAns[63:32]` = remainder (Hi) and `DivAns[31:0]` = quotient (Lo). It supports unsigned and signed (two's-complement) division, selected per operation.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 24 ++
 rtl/seq_divider.sv | 122 ++++++++++++
 tb/tb_seq_divider.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and state type for the sequential divider
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } div_state_e;

    // Quotient reported when the divisor is zero.
    localparam logic [DIV_WIDTH-1:0] DBZ_QUO = '1;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring iteration on {rem, quo} against a divisor magnitude
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < dvs holds before every step, so the top bit of trial is a clean borrow flag.
    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_i};

    assign rem_o = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle signed/unsigned restoring divider feeding Hi/Lo
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] DivAns
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvs_q;
    logic               neg_quo_q;
    logic               neg_rem_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic [2*WIDTH-1:0] ans_q;

    logic [WIDTH-1:0]   dvd_mag_d;
    logic [WIDTH-1:0]   dvs_mag_d;
    logic [WIDTH-1:0]   step_rem_d;
    logic [WIDTH-1:0]   step_quo_d;
    logic [WIDTH-1:0]   rem_fix_d;
    logic [WIDTH-1:0]   quo_fix_d;

    assign dvd_mag_d = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dvs_mag_d = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem_d),
        .quo_o (step_quo_d)
    );

    // The final step's output is fixed up and registered straight into DivAns.
    assign rem_fix_d = neg_rem_q ? -step_rem_d : step_rem_d;
    assign quo_fix_d = neg_quo_q ? -step_quo_d : step_quo_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            ans_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (divisor == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                            ans_q   <= {dividend, DBZ_QUO[WIDTH-1:0]};
                        end else begin
                            state_q   <= S_RUN;
                            cnt_q     <= '0;
                            rem_q     <= '0;
                            quo_q     <= dvd_mag_d;
                            dvs_q     <= dvs_mag_d;
                            neg_quo_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            neg_rem_q <= is_signed && dividend[WIDTH-1];
                        end
                    end
                end
                S_RUN: begin
                    rem_q <= step_rem_d;
                    quo_q <= step_quo_d;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        dbz_q   <= 1'b0;
                        ans_q   <= {rem_fix_d, quo_fix_d};
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign DivAns      = ans_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [63:0] DivAns;

    typedef struct {
        logic [63:0] ans;
        logic        dbz;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   lat;
    int   bcnt;

    seq_divider dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .DivAns      (DivAns)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb, q, r;
        if (b == 32'd0) begin
            e.ans = {a, 32'hFFFF_FFFF};
            e.dbz = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            e.ans = {r[31:0], q[31:0]};
            e.dbz = 1'b0;
        end else begin
            e.ans = {a % b, a / b};
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("div_ans", DivAns, e.ans);
                chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
            end
        end
    end

    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic push, input logic [63:0] ans, input logic dbz);
        exp_t e;
        int   w;
        w = 0;
        @(negedge clk);
        while (busy && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) chk("idle_timeout", 64'd0, 64'd1);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        if (push) begin
            e.ans = ans;
            e.dbz = dbz;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int l, output int bc);
        l  = 0;
        bc = 0;
        forever begin
            @(negedge clk);
            l++;
            if (busy) bc++;
            if (done) break;
            if (l >= 80) begin
                chk("done_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(negedge clk);
        chk("done_width", {63'd0, done}, 64'd0);
        chk("busy_after_done", {63'd0, busy}, 64'd0);
    endtask

    task automatic op(input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] ans, input logic dbz);
        int l, bc;
        launch(s, a, b, 1'b1, ans, dbz);
        wait_done(l, bc);
    endtask

    initial begin
        exp_t e;
        logic [31:0] a, b;
        logic        s;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        chk("rst_ans", DivAns, 64'd0);
        reset = 1'b1;

        launch(1'b0, 32'd100, 32'd7, 1'b1, 64'h00000002_0000000E, 1'b0);
        wait_done(lat, bcnt);
        chk("latency_100_7", 64'(lat), 64'd33);
        chk("busy_cycles", 64'(bcnt), 64'd33);
        repeat (3) @(negedge clk);
        chk("ans_hold", DivAns, 64'h00000002_0000000E);

        op(1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
        op(1'b0, 32'hFFFF_FFF9, 32'd2, 64'h00000001_7FFFFFFC, 1'b0);

        launch(1'b0, 32'd5, 32'd0, 1'b1, 64'h00000005_FFFFFFFF, 1'b1);
        wait_done(lat, bcnt);
        chk("latency_dbz", 64'(lat), 64'd1);
        chk("dbz_hold", {63'd0, div_by_zero}, 64'd1);
        op(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0);

        op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 1'b0);

        launch(1'b0, 32'd100, 32'd7, 1'b0, 64'd0, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_ans", DivAns, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        repeat (40) @(negedge clk);
        op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);

        launch(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1, 64'h00000000_FFFFFFFF, 1'b0);
        repeat (5) @(negedge clk);
        dividend = 32'd8;
        divisor  = 32'd2;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bcnt);
        repeat (40) @(negedge clk);
        chk("no_queued_start", 64'(exp_q.size()), 64'd0);

        for (int i = 0; i < 24; i++) begin
            s = i[0];
            a = $urandom;
            b = (i % 8 == 5) ? 32'd0 : ((i % 3 == 0) ? $urandom_range(1, 255) : $urandom);
            e = model(s, a, b);
            op(s, a, b, e.ans, e.dbz);
        end

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
